// File: rtl/alu_serial_n_pkg.sv
// Shared types and constants for the nibble-serial 74181-style ALU.
// Holds the FSM encoding, the common op selects and the index-width helper.
package alu_serial_n_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Arithmetic selects (mode = 0)
  localparam logic [3:0] ALU_OP_ADD = 4'b1001;
  localparam logic [3:0] ALU_OP_SUB = 4'b0110;
  // Logic selects (mode = 1)
  localparam logic [3:0] ALU_OP_XOR = 4'b0110;
  localparam logic [3:0] ALU_OP_AND = 4'b1011;
  localparam logic [3:0] ALU_OP_OR  = 4'b1110;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/alu_serial_n_alu_4.sv
// Behavioural 4-bit 74181 slice, active-high data, active-low carry in/out.
// Arithmetic result is P + G + carry; logic result is the carry-free XNOR of P and G.
module alu_4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [3:0] s,
  input  logic       m,
  input  logic       cn,
  output logic [3:0] f,
  output logic       cn4,
  output logic       pg,
  output logic       gg
);

  logic [3:0] p;
  logic [3:0] g;
  logic [4:0] sum;

  // G is always a subset of P, so P and G double as propagate and generate.
  assign p   = a | (b & {4{s[0]}}) | (~b & {4{s[1]}});
  assign g   = (a & ~b & {4{s[2]}}) | (a & b & {4{s[3]}});
  assign sum = {1'b0, p} + {1'b0, g} + {4'b0000, ~cn};

  assign f   = m ? ~(p ^ g) : sum[3:0];
  assign cn4 = ~sum[4];
  assign pg  = ~(&p);
  assign gg  = ~(g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]));

endmodule

// File: rtl/alu_serial_n.sv
// Nibble-serial WIDTH-bit ALU: one alu_4 slice per clock, LSB nibble first,
// ripple carry held in a register between slices; start/done handshake.
module alu_serial_n #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       alu_op,
  input  logic             mode,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] z,
  output logic             c_out,
  output logic             zero
);
  import alu_serial_n_pkg::*;

  localparam int N     = WIDTH / 4;
  localparam int IDX_W = idx_width(N);

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [N-1:0][3:0]    x_q, x_d;
  logic [N-1:0][3:0]    y_q, y_d;
  logic [N-1:0][3:0]    acc_q, acc_d;
  logic [3:0]           op_q, op_d;
  logic                 mode_q, mode_d;
  logic                 carry_q, carry_d;
  logic [WIDTH-1:0]     z_q, z_d;
  logic                 cout_q, cout_d;
  logic                 zero_q, zero_d;

  logic [3:0]           slice_f;
  logic                 slice_cn4;
  logic                 slice_pg;
  logic                 slice_gg;
  logic                 last_slice;
  logic                 unused_slice;

  alu_4 u_slice (
    .a   (x_q[idx_q]),
    .b   (y_q[idx_q]),
    .s   (op_q),
    .m   (mode_q),
    .cn  (carry_q),
    .f   (slice_f),
    .cn4 (slice_cn4),
    .pg  (slice_pg),
    .gg  (slice_gg)
  );

  // Ripple-only design: the group lookahead outputs are intentionally dropped.
  assign unused_slice = &{1'b0, slice_pg, slice_gg};
  assign last_slice   = (idx_q == IDX_W'(N - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      z_q     <= '0;
      cout_q  <= 1'b1;
      zero_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      z_q     <= z_d;
      cout_q  <= cout_d;
      zero_q  <= zero_d;
    end
  end

  // Operand and partial-result storage needs no reset: a new op rewrites all of it.
  always_ff @(posedge clk) begin
    x_q     <= x_d;
    y_q     <= y_d;
    acc_q   <= acc_d;
    op_q    <= op_d;
    mode_q  <= mode_d;
    carry_q <= carry_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (start)      state_d = ST_RUN;
      ST_RUN:  if (last_slice) state_d = ST_DONE;
      ST_DONE:                 state_d = ST_IDLE;
      default:                 state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    x_d     = x_q;
    y_d     = y_q;
    acc_d   = acc_q;
    op_d    = op_q;
    mode_d  = mode_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    z_d     = z_q;
    cout_d  = cout_q;
    zero_d  = zero_q;
    if (state_q == ST_IDLE && start) begin
      x_d     = x;
      y_d     = y;
      op_d    = alu_op;
      mode_d  = mode;
      carry_d = c_in;
      idx_d   = '0;
    end else if (state_q == ST_RUN) begin
      acc_d[idx_q] = slice_f;
      carry_d      = slice_cn4;
      idx_d        = idx_q + IDX_W'(1);
      // Visible result is published in one step so no partial z ever shows.
      if (last_slice) begin
        z_d    = acc_d;
        cout_d = slice_cn4;
        zero_d = (acc_d == '0);
      end
    end
  end

  always_comb begin
    busy = (state_q == ST_RUN) || (state_q == ST_DONE);
    done = (state_q == ST_DONE);
  end

  assign z     = z_q;
  assign c_out = cout_q;
  assign zero  = zero_q;

endmodule
